uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Synthesizable UART transmitter that serializes one byte per request with a selectable parity bit. It is the upstream stage of the rx receiver: its tx_out drives rx din directly. The frame format matches rx:
- 1 start bit
- 8 data bits, LSB first
- 1 parity bit
- 1 stop bit

That is 11 bit times per character. It replaces the behavioural transmitter model in system-level loopback benches.

Parameters:
CLK_FREQUENCY, 100000000, system clock frequency in Hz
BAUD_RATE, 19200, serial bit rate in bits/s
BAUD_CLOCKS, CLK_FREQUENCY/BAUD_RATE (5208 at defaults), derived localparam: clock cycles per bit, integer division truncates

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
send  input  1  transmit request, level-sensitive, synchronous to clk
din  input  8  byte to transmit, sampled at acceptance
parity_mode  input  1  1 = odd parity, 0 = even parity, sampled at acceptance
tx_out  output  1  serial line, idle high, registered
busy  output  1  high while a frame is in progress or while waiting for send release

Behaviour:
- Reset (rst=0, asynchronous): tx_out=1, busy=0, state=IDLE, bit counter=0, baud counter=0. Reset asserted mid-frame aborts immediately; tx_out returns to 1 with no glitch to 0.
- States: IDLE, START, DATA, PARITY, STOP, RELEASE.
- IDLE: tx_out=1, busy=0.
  - On a rising clk edge with send=1: latch din into shift register and parity_mode into a parity register; clear baud counter; go to START.
  - At acceptance, parity bit = ~^din for odd mode, ^din for even mode.
- START: tx_out=0 for exactly BAUD_CLOCKS cycles, then DATA.
- DATA: tx_out = shift_reg[0]. Each bit is held BAUD_CLOCKS cycles, then the register shifts right. After bit index 7 completes (3-bit counter reaches 7 and baud tick occurs), go to PARITY.
- PARITY: tx_out = latched parity bit for BAUD_CLOCKS cycles, then STOP.
- STOP: tx_out=1 for BAUD_CLOCKS cycles. At the tick:
  - send=0: go to IDLE.
  - send=1: go to RELEASE.
- RELEASE: tx_out=1, busy=1; return to IDLE on the first cycle send=0. A held send therefore never produces a second frame; one frame per request.
- Latency: tx_out falls on the clk edge after the one that samples send=1 (1 cycle). busy rises on that same edge.
- busy=1 in START, DATA, PARITY, STOP, RELEASE.
- Frame length: exactly 11*BAUD_CLOCKS cycles from tx_out falling to STOP end.
- Baud counter: runs 0..BAUD_CLOCKS-1, wraps to 0 and emits a one-cycle tick at BAUD_CLOCKS-1. It is cleared on acceptance and has no free-running phase relation to idle time.
- Width: ceil(log2(BAUD_CLOCKS)) bits.
- Input isolation: din and parity_mode changes after acceptance have no effect on the current frame.
- send asserted during any non-IDLE state is ignored; it is not queued.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP, RELEASE)
  - PARITY_ODD=1'b1 and PARITY_EVEN=1'b0 constants
  - DATA_BITS=8
  - FRAME_BITS=11
- One sub-module, baud_gen:
  - parameter BAUD_CLOCKS
  - inputs clk, rst, clear
  - output tick
  - Instantiated once in uart_tx; reusable by rx.

Test Plan:
1. Reset: hold rst=0 for 80ns, release on negedge -> tx_out=1, busy=0; with send=0 for 10us, tx_out stays 1.
2. Odd parity: din=0x55, parity_mode=1, send pulsed 2 cycles.
   - Expected line sequence: 0,1,0,1,0,1,0,1,0,1(parity),1(stop).
   - Each bit 5208 cycles ±0; busy falls exactly 11*5208 cycles after tx_out falls.
3. Even parity: din=0xA3, parity_mode=0.
   - Expected data bits LSB-first: 1,1,0,0,0,1,0,1.
   - Parity bit=0.
   - Changing din to 0xFF mid-frame does not alter the bits.
4. Held request: send held high for 3 frame times with din=0x3C -> exactly one frame. busy stays 1 through RELEASE and drops 1 cycle after send=0.
5. Reset mid-frame: assert rst=0 during DATA bit 4 -> tx_out=1 and busy=0 asynchronously. A subsequent send of 0x81 yields a clean full frame.
6. Loopback: uart_tx.tx_out -> rx.din with 10 random bytes, parity_mode=1.
   - rx dout matches each byte and rx_error=0.
   - Repeat one byte with uart_tx parity_mode=0 -> rx_error=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter (and receiver).
//   tx_state_t  - transmitter FSM states
//   PARITY_*    - parity_mode encodings
//   DATA_BITS   - data bits per character
//   FRAME_BITS  - start + data + parity + stop
//   calc_parity - parity bit for a byte under a given mode
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RELEASE
    } tx_state_t;

    localparam logic PARITY_ODD  = 1'b1;
    localparam logic PARITY_EVEN = 1'b0;
    localparam int   DATA_BITS   = 8;
    localparam int   FRAME_BITS  = 11;

    function automatic logic calc_parity(logic [DATA_BITS-1:0] d, logic mode);
        return (mode == PARITY_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: request/line bundle of the UART transmitter.
//   send        - transmit request (level)
//   din         - byte to transmit
//   parity_mode - 1 = odd, 0 = even
//   tx_out      - serial line, idle high
//   busy        - frame in progress or waiting for send release
interface uart_tx_if;
    import uart_pkg::*;

    logic                 send;
    logic [DATA_BITS-1:0] din;
    logic                 parity_mode;
    logic                 tx_out;
    logic                 busy;

    modport master (output send, din, parity_mode, input tx_out, busy);
    modport slave  (input send, din, parity_mode, output tx_out, busy);

endinterface

// File: rtl/uart_tx_baud_gen.sv
// baud_gen: bit-period timer producing a one-cycle tick every BAUD_CLOCKS cycles.
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   clear - synchronous restart of the period (holds the count at 0)
//   tick  - high on the last cycle of each bit period
module baud_gen #(
    parameter int BAUD_CLOCKS = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = (BAUD_CLOCKS > 1) ? $clog2(BAUD_CLOCKS) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(BAUD_CLOCKS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 1 start, 8 data (LSB first), 1 parity, 1 stop bit.
//   clk - system clock
//   rst - asynchronous active-low reset
//   bus - uart_tx_if slave: send/din/parity_mode in, tx_out/busy out
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100000000,
    parameter int BAUD_RATE     = 19200
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic [2:0]           bit_cnt;
    logic                 tx_q;
    logic                 busy_q;
    logic                 tick;
    logic                 baud_clear;

    // Holding the timer at zero while idle makes every frame start a fresh
    // bit period on the acceptance edge.
    assign baud_clear = (state == IDLE) || (state == RELEASE);

    baud_gen #(.BAUD_CLOCKS(BAUD_CLOCKS)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (tick)
    );

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;

    // tx_q always carries the level of the bit being sent, so each transition
    // loads the next bit's value directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.send) begin
                        shift_reg  <= bus.din;
                        parity_bit <= calc_parity(bus.din, bus.parity_mode);
                        bit_cnt    <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q  <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            tx_q  <= parity_bit;
                            state <= PARITY;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            tx_q      <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        busy_q <= bus.send;
                        state  <= bus.send ? RELEASE : IDLE;
                    end
                end
                RELEASE: begin
                    if (!bus.send) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a waveform-level reference model.
module tb_uart_tx;
    localparam int CLK_F = 1600;
    localparam int BAUD  = 100;
    localparam int B     = CLK_F / BAUD;
    localparam int FL    = 11 * B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    uart_tx_if bus();

    uart_tx #(.CLK_FREQUENCY(CLK_F), .BAUD_RATE(BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Line levels of one character, index 0 = start bit ... 10 = stop bit.
    function automatic logic [10:0] frame_bits(logic [7:0] d, logic odd);
        int  ones;
        logic p;
        ones = $countones(d);
        p = odd ? (ones % 2 == 0) : (ones % 2 == 1);
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic test_reset();
        int lows;
        bus.send = 1'b0;
        bus.din = 8'h00;
        bus.parity_mode = 1'b0;
        #2 rst = 1'b0;
        #80;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx_out: got %b want 1", bus.tx_out); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL idle_line: %0d non-idle cycles, want 0", lows); end
    endtask

    // Sends one byte and compares tx_out/busy against the expected waveform
    // on every cycle, which also pins each bit width and the busy fall.
    task automatic send_and_check(string name, logic [7:0] d, logic m, int send_cycles, bit change);
        logic [10:0] fb;
        logic el, eb;
        int bad_line, bad_busy, first;
        fb = frame_bits(d, m);
        bad_line = 0;
        bad_busy = 0;
        first = -1;
        @(negedge clk);
        bus.din = d;
        bus.parity_mode = m;
        bus.send = 1'b1;
        for (int i = 0; i < FL + 4; i++) begin
            @(negedge clk);
            el = (i < FL) ? fb[i / B] : 1'b1;
            eb = (i < FL);
            if (bus.tx_out !== el) begin bad_line++; if (first < 0) first = i; end
            if (bus.busy !== eb) bad_busy++;
            if (i == send_cycles - 1) bus.send = 1'b0;
            if (change && i == 3 * B) begin bus.din = 8'hFF; bus.parity_mode = ~m; end
        end
        checks++;
        if (bad_line != 0) begin
            errors++;
            $display("FAIL %s_line: %0d wrong cycles (first at %0d), want 0 for byte %h", name, bad_line, first, d);
        end
        checks++;
        if (bad_busy != 0) begin errors++; $display("FAIL %s_busy: %0d wrong cycles, want 0", name, bad_busy); end
    endtask

    task automatic test_odd_parity();
        send_and_check("odd_55", 8'h55, 1'b1, 2, 1'b0);
    endtask

    task automatic test_even_parity();
        send_and_check("even_a3", 8'hA3, 1'b0, 1, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++)
            send_and_check("random", 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(1, 5), 1'b1);
    endtask

    task automatic test_held();
        logic [10:0] fb;
        logic m;
        int bad;
        m = $urandom_range(0, 1) == 1;
        fb = frame_bits(8'h3C, m);
        bad = 0;
        @(negedge clk);
        bus.din = 8'h3C;
        bus.parity_mode = m;
        bus.send = 1'b1;
        for (int i = 0; i < 3 * FL; i++) begin
            @(negedge clk);
            if (bus.tx_out !== ((i < FL) ? fb[i / B] : 1'b1) || bus.busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL held_frame: %0d wrong cycles, want 0", bad); end
        bus.send = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_release: busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.din = 8'($urandom);
        bus.parity_mode = 1'b1;
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        repeat (5 * B + B / 2 - 1) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.tx_out !== 1'b1) begin errors++; $display("FAIL midreset_tx_out: got %b want 1", bus.tx_out); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_and_check("after_reset", 8'h81, $urandom_range(0, 1) == 1, 1, 1'b0);
    endtask

    // Mid-bit sampling receiver, decoding as a downstream rx would.
    task automatic rx_one(logic [7:0] d, logic m, logic rx_odd, output logic [7:0] dout, output logic err);
        int t;
        logic p, stop;
        dout = '0;
        err = 1'b0;
        @(negedge clk);
        bus.din = d;
        bus.parity_mode = m;
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        t = 0;
        while (bus.tx_out !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        if (t == 20) begin
            errors++;
            $display("FAIL rx_start_timeout: no start bit within %0d cycles", t);
            err = 1'b1;
            return;
        end
        repeat (B / 2) @(negedge clk);
        if (bus.tx_out !== 1'b0) err = 1'b1;
        for (int k = 0; k < 8; k++) begin
            repeat (B) @(negedge clk);
            dout[k] = bus.tx_out;
        end
        repeat (B) @(negedge clk);
        p = bus.tx_out;
        repeat (B) @(negedge clk);
        stop = bus.tx_out;
        if (stop !== 1'b1) err = 1'b1;
        if (($countones({dout, p}) % 2 == 1) != rx_odd) err = 1'b1;
        t = 0;
        while (bus.busy !== 1'b0 && t < 2 * B) begin @(negedge clk); t++; end
        if (t == 2 * B) begin errors++; $display("FAIL rx_busy_timeout: busy still high"); end
    endtask

    task automatic test_loopback();
        logic [7:0] d, dout;
        logic err;
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            rx_one(d, 1'b1, 1'b1, dout, err);
            checks++;
            if (dout !== d) begin errors++; $display("FAIL loop_dout: got %h want %h", dout, d); end
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL loop_err: got %b want 0 for %h", err, d); end
        end
        d = 8'($urandom);
        rx_one(d, 1'b0, 1'b1, dout, err);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL loop_parity_err: got %b want 1 for %h", err, d); end
    endtask

    initial begin
        test_reset();
        test_odd_parity();
        test_even_parity();
        test_random();
        test_held();
        test_reset_mid();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
